// File: rtl/cpu_types_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_types_pkg
// Description : Shared CPU datapath types. Holds the instruction-cache
//               address view and frame layout for the default 16-set cache.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_types_pkg;

    localparam int ICACHE_SETS = 16;
    localparam int ICACHE_IDXW = $clog2(ICACHE_SETS);
    localparam int ICACHE_TAGW = 32 - ICACHE_IDXW - 2;

    typedef logic [31:0] word_t;

    // Fetch address split into tag / frame index / byte offset.
    typedef struct packed {
        logic [ICACHE_TAGW-1:0] tag;
        logic [ICACHE_IDXW-1:0] idx;
        logic [1:0]             bytoff;
    } icachef_t;

    // One direct-mapped frame: single instruction word.
    typedef struct packed {
        logic                   valid;
        logic [ICACHE_TAGW-1:0] tag;
        word_t                  data;
    } icache_frame_t;

endpackage
`default_nettype wire

// File: rtl/dp_types_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dp_types_pkg
// Description : Datapath-side controller state types.
// Revision    : 1.0 - initial release
// ============================================================================
package dp_types_pkg;

    // Instruction cache controller: look up, or wait on the arbiter fill.
    typedef enum logic [0:0] {
        COMPARE = 1'b0,
        FETCH   = 1'b1
    } icache_state_t;

endpackage
`default_nettype wire

// File: rtl/icache.sv
`default_nettype none
// ============================================================================
// Module      : icache
// Description : Direct-mapped, one-word-per-frame instruction cache sitting
//               between the datapath fetch port and the memory arbiter.
//               Hits answer combinationally; a miss issues a single-word
//               read, fills the frame, and the request then hits.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   CLK, RST             clock, synchronous active-high reset
//   imemREN, imemaddr    datapath fetch request / byte address
//   ihit, imemload       instruction valid / instruction word
//   iREN, iaddr          read request / word address to the arbiter
//   iwait, iload         arbiter busy / read data
//   hit_count            saturating count of hit cycles
//   miss_count           saturating count of misses
// ============================================================================
module icache
    import cpu_types_pkg::*;
    import dp_types_pkg::*;
#(
    parameter int SETS = 16,
    parameter int CNTW = 32
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            imemREN,
    input  logic [31:0]     imemaddr,
    output logic            ihit,
    output logic [31:0]     imemload,
    output logic            iREN,
    output logic [31:0]     iaddr,
    input  logic            iwait,
    input  logic [31:0]     iload,
    output logic [CNTW-1:0] hit_count,
    output logic [CNTW-1:0] miss_count
);

    localparam int IDXW = $clog2(SETS);
    localparam int TAGW = 32 - IDXW - 2;

    icache_state_t         r_state;
    icache_state_t         w_next_state;

    logic [SETS-1:0]       r_valid;
    logic [TAGW-1:0]       r_tag  [SETS];
    word_t                 r_data [SETS];

    // Word address of the outstanding miss (byte offset is never needed).
    logic [29:0]           r_miss_waddr;

    logic [CNTW-1:0]       r_hit_count;
    logic [CNTW-1:0]       r_miss_count;

    logic [TAGW-1:0]       w_tag;
    logic [IDXW-1:0]       w_idx;
    logic [IDXW-1:0]       w_fill_idx;
    logic                  w_lookup_hit;
    logic                  w_miss;
    logic                  w_fill;
    logic                  w_unused_bytoff;

    assign w_tag           = imemaddr[31:IDXW+2];
    assign w_idx           = imemaddr[IDXW+1:2];
    assign w_fill_idx      = r_miss_waddr[IDXW-1:0];
    assign w_unused_bytoff = ^imemaddr[1:0];

    assign w_lookup_hit = imemREN & r_valid[w_idx] & (r_tag[w_idx] == w_tag);
    assign imemload     = r_data[w_idx];

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;

    // ------------------------------------------------------------------
    // Next state and handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        ihit         = 1'b0;
        iREN         = 1'b0;
        iaddr        = 32'h0;
        w_miss       = 1'b0;
        w_fill       = 1'b0;
        case (r_state)
            COMPARE: begin
                ihit = w_lookup_hit;
                if (imemREN && !w_lookup_hit) begin
                    w_miss       = 1'b1;
                    w_next_state = FETCH;
                end
            end
            FETCH: begin
                // The request stays up regardless of imemREN/imemaddr so the
                // arbiter never sees an abandoned read.
                iREN  = 1'b1;
                iaddr = {r_miss_waddr, 2'b00};
                if (!iwait) begin
                    w_fill       = 1'b1;
                    w_next_state = COMPARE;
                end
            end
            default: w_next_state = COMPARE;
        endcase
    end

    // ------------------------------------------------------------------
    // Control state, valid bits, miss address and statistics
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state      <= COMPARE;
            r_valid      <= '0;
            r_miss_waddr <= '0;
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_fill) begin
                r_valid[w_fill_idx] <= 1'b1;
            end
            if (w_miss) begin
                r_miss_waddr <= imemaddr[31:2];
            end
            if (ihit && (r_hit_count != '1)) begin
                r_hit_count <= r_hit_count + CNTW'(1);
            end
            if (w_miss && (r_miss_count != '1)) begin
                r_miss_count <= r_miss_count + CNTW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Tag and data arrays: no reset, validity is tracked by r_valid.
    // A fill racing a reset is dropped so the discarded read leaves no trace.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!RST && w_fill) begin
            r_tag[w_fill_idx]  <= r_miss_waddr[29:IDXW];
            r_data[w_fill_idx] <= iload;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_icache.sv
`default_nettype none
// ============================================================================
// Module      : tb_icache
// Description : Self-checking bench for icache. Directed scenarios followed by
//               randomized traffic, all checked against a behavioural model.
//               A second instance with 2-bit counters exercises saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_icache;

    logic        CLK;
    logic        RST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        iwait;
    logic [31:0] iload;

    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    logic        s_ihit;
    logic [31:0] s_imemload;
    logic        s_iREN;
    logic [31:0] s_iaddr;
    logic [1:0]  s_hit_count;
    logic [1:0]  s_miss_count;

    icache #(.SETS(16), .CNTW(32)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .imemREN    (imemREN),
        .imemaddr   (imemaddr),
        .ihit       (ihit),
        .imemload   (imemload),
        .iREN       (iREN),
        .iaddr      (iaddr),
        .iwait      (iwait),
        .iload      (iload),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    icache #(.SETS(16), .CNTW(2)) dut_sat (
        .CLK        (CLK),
        .RST        (RST),
        .imemREN    (imemREN),
        .imemaddr   (imemaddr),
        .ihit       (s_ihit),
        .imemload   (s_imemload),
        .iREN       (s_iREN),
        .iaddr      (s_iaddr),
        .iwait      (iwait),
        .iload      (iload),
        .hit_count  (s_hit_count),
        .miss_count (s_miss_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- behavioural reference ----------------
    logic        m_valid [16];
    logic [31:0] m_tag   [16];
    logic [31:0] m_data  [16];
    logic        m_pend;
    logic [31:0] m_paddr;
    logic [31:0] m_hit;
    logic [31:0] m_miss;
    logic [1:0]  m_shit;
    logic [1:0]  m_smiss;

    function automatic int idx_of(input logic [31:0] a);
        return int'((a / 4) % 16);
    endfunction

    function automatic logic [31:0] tag_of(input logic [31:0] a);
        return a / 64;
    endfunction

    // Backing memory contents, keyed by word address.
    function automatic logic [31:0] mem(input logic [31:0] a);
        logic [31:0] w;
        w = a & 32'hFFFF_FFFC;
        if (w == 32'h0) return 32'h3C01_0001;
        return (w * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
        m_pend  = 1'b0;
        m_paddr = 32'h0;
        m_hit   = 32'h0;
        m_miss  = 32'h0;
        m_shit  = 2'd0;
        m_smiss = 2'd0;
    endtask

    // One clock cycle: drive inputs, check at the falling edge, advance the
    // model at the rising edge.
    task automatic cyc(input logic ren, input logic [31:0] a, input logic w, input logic r);
        logic exp_hit;
        int   x;
        RST      = r;
        imemREN  = ren;
        imemaddr = a;
        iwait    = w;
        iload    = m_pend ? mem(m_paddr) : $urandom();
        @(negedge CLK);
        x = idx_of(a);
        exp_hit = !m_pend && ren && m_valid[x] && (m_tag[x] == tag_of(a));
        check("ihit", {31'b0, ihit}, {31'b0, exp_hit});
        check("iREN", {31'b0, iREN}, {31'b0, m_pend});
        check("iaddr", iaddr, m_pend ? (m_paddr & 32'hFFFF_FFFC) : 32'h0);
        if (exp_hit) check("imemload", imemload, m_data[x]);
        check("hit_count", hit_count, m_hit);
        check("miss_count", miss_count, m_miss);
        check("sat_hit_count", {30'b0, s_hit_count}, {30'b0, m_shit});
        check("sat_miss_count", {30'b0, s_miss_count}, {30'b0, m_smiss});
        @(posedge CLK);
        if (r) begin
            model_reset();
        end else begin
            if (exp_hit) begin
                if (m_hit != 32'hFFFF_FFFF) m_hit = m_hit + 1;
                if (m_shit != 2'd3) m_shit = m_shit + 2'd1;
            end
            if (m_pend) begin
                if (!w) begin
                    x = idx_of(m_paddr);
                    m_valid[x] = 1'b1;
                    m_tag[x]   = tag_of(m_paddr);
                    m_data[x]  = mem(m_paddr);
                    m_pend     = 1'b0;
                end
            end else if (ren && !exp_hit) begin
                m_pend  = 1'b1;
                m_paddr = a;
                if (m_miss != 32'hFFFF_FFFF) m_miss = m_miss + 1;
                if (m_smiss != 2'd3) m_smiss = m_smiss + 2'd1;
            end
        end
        #1;
    endtask

    logic [31:0] pool [8];

    initial begin
        RST      = 1'b1;
        imemREN  = 1'b0;
        imemaddr = 32'h0;
        iwait    = 1'b0;
        iload    = 32'h0;
        repeat (2) @(posedge CLK);
        #1;
        model_reset();

        // Reset held: outputs quiet.
        cyc(1'b0, 32'h0, 1'b0, 1'b1);
        cyc(1'b0, 32'h0, 1'b0, 1'b0);

        // Cold miss on 0x0: two busy cycles, completion, then hit.
        cyc(1'b1, 32'h0, 1'b0, 1'b0);
        cyc(1'b1, 32'h0, 1'b1, 1'b0);
        cyc(1'b1, 32'h0, 1'b1, 1'b0);
        cyc(1'b1, 32'h0, 1'b0, 1'b0);
        check("t1_ihit", {31'b0, ihit}, 32'h1);
        check("t1_load", imemload, 32'h3C01_0001);
        check("t1_miss_count", miss_count, 32'd1);

        // Repeated hits, zero latency.
        cyc(1'b1, 32'h0, 1'b0, 1'b0);
        cyc(1'b1, 32'h2, 1'b0, 1'b0);
        cyc(1'b1, 32'h0, 1'b0, 1'b0);

        // Same-index conflict: 0x40 replaces 0x0, then 0x0 misses again.
        cyc(1'b1, 32'h40, 1'b0, 1'b0);
        cyc(1'b1, 32'h40, 1'b1, 1'b0);
        cyc(1'b1, 32'h40, 1'b0, 1'b0);
        cyc(1'b1, 32'h40, 1'b0, 1'b0);
        cyc(1'b1, 32'h0, 1'b0, 1'b0);
        cyc(1'b1, 32'h0, 1'b0, 1'b0);
        cyc(1'b1, 32'h0, 1'b0, 1'b0);
        check("t3_miss_count", miss_count, 32'd3);

        // Redirect and dropped request while filling 0x4.
        cyc(1'b1, 32'h4, 1'b0, 1'b0);
        cyc(1'b0, 32'h100, 1'b1, 1'b0);
        cyc(1'b0, 32'h100, 1'b0, 1'b0);
        cyc(1'b1, 32'h100, 1'b0, 1'b0);
        cyc(1'b1, 32'h100, 1'b0, 1'b0);
        cyc(1'b1, 32'h4, 1'b0, 1'b0);

        // Reset in the middle of a fill.
        cyc(1'b1, 32'h8, 1'b1, 1'b0);
        cyc(1'b1, 32'h8, 1'b1, 1'b0);
        cyc(1'b1, 32'h8, 1'b1, 1'b1);
        check("rst_iREN", {31'b0, iREN}, 32'h0);
        check("rst_hit_count", hit_count, 32'h0);
        check("rst_miss_count", miss_count, 32'h0);
        cyc(1'b1, 32'h4, 1'b0, 1'b0);

        // Randomized traffic over a small address pool with index conflicts.
        pool[0] = 32'h0000_0000; pool[1] = 32'h0000_0004;
        pool[2] = 32'h0000_0040; pool[3] = 32'h0000_0044;
        pool[4] = 32'h0000_0100; pool[5] = 32'h1000_0008;
        pool[6] = 32'h0000_0008; pool[7] = 32'hFFFF_FFFC;
        for (int n = 0; n < 3000; n++) begin
            cyc($urandom_range(0, 3) != 0,
                pool[$urandom_range(0, 7)] | 32'($urandom_range(0, 3)),
                $urandom_range(0, 2) == 0,
                $urandom_range(0, 199) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
